seq_ctrl: RTL and testbench



---
 rtl/seq_ctrl_pkg.sv | 22 ++
 rtl/seq_ctrl_if.sv | 31 +++
 rtl/seq_ctrl_next.sv | 24 ++
 rtl/seq_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_ctrl_pkg.sv
// Purpose: shared types and constants for the arbitrary-sequence counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    localparam int SEQ_LEN = 8;

    // Code loaded whenever an illegal code is seen, and the reset value of q.
    localparam logic [3:0] RESET_CODE = 4'd0;

    // Legal codes in stepping order; the last entry wraps to the first.
    localparam logic [3:0] SEQ [SEQ_LEN] = '{4'd0, 4'd2, 4'd5, 4'd7,
                                             4'd8, 4'd11, 4'd13, 4'd14};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seqState_t;

endpackage

// File: rtl/seq_ctrl_if.sv
// Purpose: host command / control / status bundle of the sequencer.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; the command is taken on an edge where both are high.
interface seq_ctrl_if #(
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_start;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_mode;
    logic              stop;
    logic              hold;
    logic [3:0]        q;
    logic              busy;
    logic              done;
    logic              err;
    logic [STEP_W-1:0] steps_done;

    // Host side: issues commands and run controls, observes status.
    modport master (
        output cmd_valid, cmd_start, cmd_steps, cmd_mode, stop, hold,
        input  cmd_ready, q, busy, done, err, steps_done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_start, cmd_steps, cmd_mode, stop, hold,
        output cmd_ready, q, busy, done, err, steps_done
    );
endinterface

// File: rtl/seq_ctrl_next.sv
// Purpose: table lookup of the successor of a 4-bit code, plus a legality flag.
// Latency: combinational.
// Backpressure: none.
// Ports: code (in, 4) -> nxt (out, 4; RESET_CODE when code is illegal), legal (out, 1).
module seq_next
    import seq_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] nxt,
    output logic       legal
);

    always_comb begin
        nxt   = RESET_CODE;
        legal = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (code == SEQ[i]) begin
                legal = 1'b1;
                nxt   = SEQ[(i == SEQ_LEN - 1) ? 0 : i + 1];
            end
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Purpose: command-driven sequencer owning the counter code q; loads, steps N times or free-runs, holds, stops.
// Latency: accept edge -> q=start one edge later (LOAD) -> first step on the following edge.
// Backpressure: cmd_ready only in IDLE; commands presented at other times wait.
// Ports: C clock, R sync active-high reset, bus (seq_ctrl_if.slave) for commands, stop/hold and status.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int STEP_W = 8
)(
    input  logic      C,
    input  logic      R,
    seq_ctrl_if.slave bus
);

    seqState_t         state;
    logic [3:0]        q;
    logic [3:0]        startLat;
    logic [STEP_W-1:0] stepsLat;
    logic [STEP_W-1:0] stepsDone;
    logic [STEP_W-1:0] stepsInc;
    logic              modeLat;
    logic              busy;
    logic              done;
    logic              err;

    // One lookup serves both uses: in LOAD it vets the latched start code,
    // in RUN it supplies the successor of q (RESET_CODE if q is illegal).
    logic [3:0] lookCode;
    logic [3:0] lookNext;
    logic       lookLegal;

    assign lookCode = (state == LOAD) ? startLat : q;

    seq_next uNext (
        .code  (lookCode),
        .nxt   (lookNext),
        .legal (lookLegal)
    );

    assign stepsInc = stepsDone + 1'b1;

    always_ff @(posedge C) begin
        if (R) begin
            state     <= IDLE;
            q         <= RESET_CODE;
            startLat  <= RESET_CODE;
            stepsLat  <= '0;
            stepsDone <= '0;
            modeLat   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.cmd_valid) begin
                        startLat  <= bus.cmd_start;
                        stepsLat  <= bus.cmd_steps;
                        modeLat   <= bus.cmd_mode;
                        err       <= 1'b0;
                        stepsDone <= '0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    q <= lookLegal ? startLat : RESET_CODE;
                    if (!lookLegal) begin
                        err <= 1'b1;
                    end
                    if (!modeLat && stepsLat == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!bus.hold) begin
                        // An illegal q steps to RESET_CODE and flags err; still a step.
                        q <= lookNext;
                        if (!lookLegal) begin
                            err <= 1'b1;
                        end
                        if (!modeLat) begin
                            stepsDone <= stepsInc;
                            if (stepsInc == stepsLat) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else if (stepsDone != '1) begin
                            stepsDone <= stepsInc;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.q          = q;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.steps_done = stepsDone;

endmodule

// File: tb/tb_seq_ctrl.sv
// Purpose: self-checking bench for seq_ctrl and its seq_next lookup.
// Latency: inputs driven and outputs sampled on the falling edge of C.
// Backpressure: commands held until cmd_ready is seen.
module tb_seq_ctrl;

    logic C = 1'b0;
    logic R = 1'b1;
    always #5 C = ~C;

    seq_ctrl_if #(.STEP_W(8)) bus ();

    seq_ctrl #(.STEP_W(8)) dut (
        .C   (C),
        .R   (R),
        .bus (bus.slave)
    );

    logic [3:0] vCode;
    logic [3:0] vNxt;
    logic       vLegal;

    seq_next uRef (
        .code  (vCode),
        .nxt   (vNxt),
        .legal (vLegal)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] tbl [8] = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd8, 4'd11, 4'd13, 4'd14};

    logic [3:0] expQ [$];

    typedef struct {
        logic [3:0] code;
        logic [3:0] nxt;
        logic       legal;
    } lookVec_t;

    typedef struct {
        logic [3:0] start;
        logic [7:0] steps;
        logic       expErr;
    } cmdVec_t;

    lookVec_t lookVecs [16];
    cmdVec_t  cmdVecs [5];

    function automatic logic modelLegal(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (tbl[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] modelNext(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (tbl[i] == c) return tbl[(i + 1) % 8];
        return 4'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge C);
    endtask

    // Mode-0 run: the expected q per edge is queued when the command is driven,
    // then popped and compared once per edge from the LOAD edge onwards.
    task automatic runCmd(input cmdVec_t v, input int idx);
        logic [3:0] c;
        logic [3:0] lastQ;
        lastQ = 4'd0;
        bus.cmd_valid = 1'b1;
        bus.cmd_start = v.start;
        bus.cmd_steps = v.steps;
        bus.cmd_mode  = 1'b0;
        chk($sformatf("cmd%0d_ready", idx), bus.cmd_ready, 1);
        c = modelLegal(v.start) ? v.start : 4'd0;
        expQ.push_back(c);
        for (int i = 0; i < int'(v.steps); i++) begin
            c = modelNext(c);
            expQ.push_back(c);
        end
        tick();
        bus.cmd_valid = 1'b0;
        chk($sformatf("cmd%0d_busy_load", idx), bus.busy, 1);
        chk($sformatf("cmd%0d_err_cleared", idx), bus.err, 0);
        while (expQ.size() > 0) begin
            tick();
            lastQ = expQ.pop_front();
            chk($sformatf("cmd%0d_q", idx), bus.q, lastQ);
        end
        chk($sformatf("cmd%0d_done", idx), bus.done, 1);
        chk($sformatf("cmd%0d_busy_done", idx), bus.busy, 0);
        chk($sformatf("cmd%0d_steps_done", idx), bus.steps_done, v.steps);
        chk($sformatf("cmd%0d_err", idx), bus.err, v.expErr);
        tick();
        chk($sformatf("cmd%0d_done_pulse", idx), bus.done, 0);
        chk($sformatf("cmd%0d_ready_after", idx), bus.cmd_ready, 1);
        chk($sformatf("cmd%0d_q_held", idx), bus.q, lastQ);
    endtask

    task automatic startFree(input logic [3:0] start);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = start;
        bus.cmd_steps = 8'd0;
        bus.cmd_mode  = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] c;
        bus.cmd_valid = 1'b0;
        bus.cmd_start = 4'd0;
        bus.cmd_steps = 8'd0;
        bus.cmd_mode  = 1'b0;
        bus.stop      = 1'b0;
        bus.hold      = 1'b0;
        vCode         = 4'd0;

        for (int i = 0; i < 16; i++) begin
            lookVecs[i].code  = 4'(i);
            lookVecs[i].nxt   = modelNext(4'(i));
            lookVecs[i].legal = modelLegal(4'(i));
        end
        cmdVecs[0] = '{start: 4'd5,  steps: 8'd4, expErr: 1'b0};
        cmdVecs[1] = '{start: 4'd13, steps: 8'd3, expErr: 1'b0};
        cmdVecs[2] = '{start: 4'd7,  steps: 8'd0, expErr: 1'b0};
        cmdVecs[3] = '{start: 4'd3,  steps: 8'd2, expErr: 1'b1};
        cmdVecs[4] = '{start: 4'd2,  steps: 8'd1, expErr: 1'b0};

        // Lookup table against the bench's own sequence.
        for (int i = 0; i < 16; i++) begin
            vCode = lookVecs[i].code;
            #1;
            chk($sformatf("lookup_nxt_%0d", i), vNxt, lookVecs[i].nxt);
            chk($sformatf("lookup_legal_%0d", i), vLegal, lookVecs[i].legal);
        end

        // Reset, then the first cycle after R drops.
        repeat (3) tick();
        R = 1'b0;
        tick();
        chk("rst_q", bus.q, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_steps_done", bus.steps_done, 0);

        for (int i = 0; i < 5; i++) runCmd(cmdVecs[i], i);

        // Free-run with hold then stop.
        startFree(4'd0);
        chk("hold_q_load", bus.q, 0);
        c = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            c = modelNext(c);
            chk("hold_q_step", bus.q, c);
        end
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q_frozen", bus.q, c);
            chk("hold_sd_frozen", bus.steps_done, 3);
            chk("hold_busy", bus.busy, 1);
        end
        bus.hold = 1'b0;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_done", bus.done, 1);
        chk("stop_q", bus.q, c);
        chk("stop_sd", bus.steps_done, 3);
        tick();
        chk("stop_ready", bus.cmd_ready, 1);

        // Free-run long enough to saturate steps_done while q keeps wrapping.
        startFree(4'd14);
        c = 4'd14;
        for (int i = 0; i < 260; i++) begin
            tick();
            c = modelNext(c);
        end
        chk("sat_steps_done", bus.steps_done, 255);
        chk("sat_q", bus.q, c);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("sat_stop_done", bus.done, 1);
        tick();

        // Command held during RUN is not taken; R aborts the run.
        startFree(4'd5);
        tick();
        chk("abort_q7", bus.q, 7);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = 4'd0;
        bus.cmd_mode  = 1'b1;
        chk("abort_ready_run", bus.cmd_ready, 0);
        tick();
        chk("abort_q8", bus.q, 8);
        tick();
        chk("abort_q11", bus.q, 11);
        R = 1'b1;
        tick();
        chk("abort_q", bus.q, 0);
        chk("abort_sd", bus.steps_done, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_busy", bus.busy, 0);
        R = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        chk("abort_accept_idle", bus.busy, 1);
        tick();
        chk("abort_load_q", bus.q, 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("abort_stop_done", bus.done, 1);
        tick();
        chk("abort_final_ready", bus.cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
